arrow_lane_engine: RTL and testbench
====================================

# arrow_lane_engine

Parametrised multi-lane arrow engine for the rhythm-game video path: tracks up to SLOTS falling arrows in each of LANES lanes. It launches arrows on request, moves them once per frame, judges button presses against a target line, and keeps a saturating score. It sits between the pattern/timing source and the pixel compositor, replacing the fixed four-lane draw/movement pairs with one configurable block that adds hit/miss judgment.

## Interface
- CORDW, 10, screen coordinate width
- LANES, 4, number of lanes (1..8)
- SLOTS, 4, arrow slots per lane
- ARROW_SIZE, 50, arrow square edge in pixels
- ARROW_GAP, 10, horizontal gap between lanes
- SCREEN_W, 640, active width used to centre lanes
- ARROWY_BEGIN, 450, launch y
- ARROW_SPEED, 10, pixels moved upward per frame
- TARGET_Y, 40, judgment line y
- HIT_WINDOW, 20, accepted |y - TARGET_Y| for a hit
- SCOREW, 16, score width
- clk_i  in  1  pixel clock
- rst_ni  in  1  asynchronous active-low reset
- sx_i, sy_i  in  CORDW  current pixel coordinates
- frame_i  in  1  one-cycle pulse per frame
- launch_i  in  LANES  one-cycle launch request per lane
- btn_i  in  LANES  debounced button levels, one per lane
- arrow_o  out  LANES  pixel (sx_i, sy_i) lies inside an active arrow of lane l
- hit_o  out  LANES  one-cycle hit pulse per lane
- miss_o  out  LANES  one-cycle miss pulse per lane
- drop_o  out  LANES  one-cycle pulse: launch refused, lane full
- score_o  out  SCOREW  running score

## Operation
- Slot state: valid bit plus y (CORDW). Reset: all slots invalid, y = 0.
- Launch: the lowest-index slot that is free in the registered state gets valid=1 and y=ARROWY_BEGIN. If no slot is free, drop_o[l] pulses and nothing changes.
- Move on frame_i: each valid slot with y >= ARROW_SPEED takes y -= ARROW_SPEED. A valid slot with y < ARROW_SPEED is freed and miss_o[l] pulses; no underflow is allowed.
- Press: a rising edge of btn_i[l] against the registered previous level. The edge register resets to all ones, so a button held through reset produces no edge.
- Hit: on an edge, among valid slots with TARGET_Y-HIT_WINDOW <= y <= TARGET_Y+HIT_WINDOW, the slot with smallest y is freed; ties go to the lowest index. hit_o[l] pulses. Compare in CORDW+1 bits signed; no wrap.
- Edge with no slot in window: no action (see Configuration).
- Score: score_o += popcount(hit_o), saturating at 2^SCOREW-1.
- Simultaneous events in one cycle:
  - Judgment uses pre-move positions.
  - Hit beats move and beats miss on the same slot.
  - A slot freed this cycle is not eligible for a launch this cycle.
  - A newly launched arrow is not moved this cycle.
- Lane x origin: (SCREEN_W - (LANES*ARROW_SIZE + (LANES-1)*ARROW_GAP))/2 + l*(ARROW_SIZE+ARROW_GAP).
- arrow_o[l]: OR over valid slots of sx in [x_l, x_l+ARROW_SIZE) and sy in [y, y+ARROW_SIZE).

## Timing
- arrow_o is combinational from registered slot state and sx_i/sy_i, with zero latency.
- hit_o, miss_o and drop_o are registered and asserted the cycle after the causing input. score_o updates on the same edge hit_o rises.
- Reset values: all outputs 0; score 0.
- Reset mid-operation clears all slots and the score immediately. No pulses are emitted for the discarded arrows.

## Configuration
- ARROW_LANE_PENALTY_EN defined: an edge with no slot in the window pulses miss_o[l] and decrements the score by one per offending lane, saturating at 0. Hits and penalties in the same cycle are summed signed before saturation.
- ARROW_LANE_PENALTY_EN undefined: stray presses are ignored; the score never decreases.

## Structure
- Package arrow_pkg holds:
  - the slot_t typedef (valid, y);
  - the default geometry constants;
  - the lane_x_f origin function.
- Sub-module arrow_lane holds one lane's slots, launch/move/hit logic, pixel test and pulses. The top instantiates it LANES times in a generate loop.
- The top owns button edge detection, score accumulation and the optional penalty.

## Test plan
- Launch lane 0, 46 frame_i pulses, no press -> y is 450 after launch and 0 after 45 frames; miss_o[0] pulses after frame 46; score 0.
- Launch lane 1, 41 frames (y=40), press btn_i[1] -> hit_o[1] one cycle later; slot freed; score 1.
- Press at y=70 (38 frames) -> no hit. With ARROW_LANE_PENALTY_EN: miss_o pulse, score stays 0 (saturation).
- Five launches into lane 2 with SLOTS=4 -> fifth gives a drop_o[2] pulse; four slots hold y=450.
- frame_i, launch_i[3] and a btn_i[3] edge in the same cycle with an arrow at y=30 -> hit pulse; new arrow at 450, not moved.
- sx=x_0+49, sy=450 with an arrow at 450 -> arrow_o[0]=1; sx=x_0+50 -> 0. Assert rst_ni mid-flight -> all outputs 0.

Source files
------------

// File: rtl/arrow_pkg.sv
// Shared slot type, default geometry and lane placement for the arrow lane engine.
package arrow_pkg;

  // Slot y storage width; the engine's CORDW must not exceed it.
  localparam int YW = 16;

  localparam int DEF_CORDW        = 10;
  localparam int DEF_LANES        = 4;
  localparam int DEF_SLOTS        = 4;
  localparam int DEF_ARROW_SIZE   = 50;
  localparam int DEF_ARROW_GAP    = 10;
  localparam int DEF_SCREEN_W     = 640;
  localparam int DEF_ARROWY_BEGIN = 450;
  localparam int DEF_ARROW_SPEED  = 10;
  localparam int DEF_TARGET_Y     = 40;
  localparam int DEF_HIT_WINDOW   = 20;
  localparam int DEF_SCOREW       = 16;

  typedef struct packed {
    logic          valid;
    logic [YW-1:0] y;
  } slot_t;

  // Left edge of a lane when all lanes are centred on the screen.
  function automatic int lane_x_f(input int lanes, input int size, input int gap,
                                  input int screen_w, input int lane);
    return (screen_w - (lanes * size + (lanes - 1) * gap)) / 2 + lane * (size + gap);
  endfunction

endpackage

// File: rtl/arrow_lane.sv
// One lane of falling arrows: slot storage, launch/move/hit judgment, pixel test
// and the registered hit/miss/drop pulses.
module arrow_lane
  import arrow_pkg::*;
#(
  parameter int CORDW        = DEF_CORDW,
  parameter int SLOTS        = DEF_SLOTS,
  parameter int ARROW_SIZE   = DEF_ARROW_SIZE,
  parameter int ARROWY_BEGIN = DEF_ARROWY_BEGIN,
  parameter int ARROW_SPEED  = DEF_ARROW_SPEED,
  parameter int TARGET_Y     = DEF_TARGET_Y,
  parameter int HIT_WINDOW   = DEF_HIT_WINDOW,
  parameter int X_ORIGIN     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             frame,
  input  logic             launch,
  input  logic             press,
  output logic             arrow,
  output logic             hit,
  output logic             miss,
  output logic             drop,
  output logic             hit_now,
  output logic             stray_now
);

  localparam int WIN_LO = TARGET_Y - HIT_WINDOW;
  localparam int WIN_HI = TARGET_Y + HIT_WINDOW;

  slot_t         slot_q [SLOTS];
  slot_t         slot_d [SLOTS];
  logic          hit_found;
  int            hit_idx;
  logic [YW-1:0] best_y;
  logic          miss_d;
  logic          drop_d;

  // Judgment uses the registered (pre-move) positions; lowest y wins, ties to lowest index.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = 0;
    best_y    = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (slot_q[s].valid && int'(slot_q[s].y) >= WIN_LO && int'(slot_q[s].y) <= WIN_HI) begin
        if (!hit_found || slot_q[s].y < best_y) begin
          hit_found = 1'b1;
          hit_idx   = s;
          best_y    = slot_q[s].y;
        end
      end
    end
  end

  assign hit_now   = press & hit_found;
  assign stray_now = press & ~hit_found;

  always_comb begin
    slot_d = slot_q;
    miss_d = 1'b0;
    drop_d = launch;
    for (int s = 0; s < SLOTS; s++) begin
      if (hit_now && s == hit_idx) begin
        slot_d[s].valid = 1'b0;
      end else if (frame && slot_q[s].valid) begin
        if (slot_q[s].y >= YW'(ARROW_SPEED)) begin
          slot_d[s].y = slot_q[s].y - YW'(ARROW_SPEED);
        end else begin
          slot_d[s].valid = 1'b0;
          miss_d          = 1'b1;
        end
      end
    end
    // Only slots already free in the registered state may take a launch.
    for (int s = 0; s < SLOTS; s++) begin
      if (drop_d && !slot_q[s].valid) begin
        slot_d[s].valid = 1'b1;
        slot_d[s].y     = YW'(ARROWY_BEGIN);
        drop_d          = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '{default: '0};
      hit    <= 1'b0;
      miss   <= 1'b0;
      drop   <= 1'b0;
    end else begin
      slot_q <= slot_d;
      hit    <= hit_now;
      miss   <= miss_d;
      drop   <= drop_d;
    end
  end

  always_comb begin
    arrow = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (slot_q[s].valid &&
          int'(sx) >= X_ORIGIN && int'(sx) < X_ORIGIN + ARROW_SIZE &&
          int'(sy) >= int'(slot_q[s].y) && int'(sy) < int'(slot_q[s].y) + ARROW_SIZE) begin
        arrow = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arrow_lane_engine.sv
// Multi-lane arrow engine: button edge detection, per-lane arrow_lane instances, saturating score.
// Optional stray-press penalty enabled by defining ARROW_LANE_PENALTY_EN.
module arrow_lane_engine
  import arrow_pkg::*;
#(
  parameter int CORDW        = DEF_CORDW,
  parameter int LANES        = DEF_LANES,
  parameter int SLOTS        = DEF_SLOTS,
  parameter int ARROW_SIZE   = DEF_ARROW_SIZE,
  parameter int ARROW_GAP    = DEF_ARROW_GAP,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int ARROWY_BEGIN = DEF_ARROWY_BEGIN,
  parameter int ARROW_SPEED  = DEF_ARROW_SPEED,
  parameter int TARGET_Y     = DEF_TARGET_Y,
  parameter int HIT_WINDOW   = DEF_HIT_WINDOW,
  parameter int SCOREW       = DEF_SCOREW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [CORDW-1:0]  sx_i,
  input  logic [CORDW-1:0]  sy_i,
  input  logic              frame_i,
  input  logic [LANES-1:0]  launch_i,
  input  logic [LANES-1:0]  btn_i,
  output logic [LANES-1:0]  arrow_o,
  output logic [LANES-1:0]  hit_o,
  output logic [LANES-1:0]  miss_o,
  output logic [LANES-1:0]  drop_o,
  output logic [SCOREW-1:0] score_o
);

  localparam int SW = SCOREW + 2;

  logic [LANES-1:0]  btn_q;
  logic [LANES-1:0]  press;
  logic [LANES-1:0]  hit_now;
  logic [LANES-1:0]  stray_now;
  logic [LANES-1:0]  lane_miss;
  logic signed [SW-1:0] score_sum;
  logic [SCOREW-1:0] score_d;

  // Resetting to ones means a button held through reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) btn_q <= '1;
    else         btn_q <= btn_i;
  end

  assign press = btn_i & ~btn_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    arrow_lane #(
      .CORDW       (CORDW),
      .SLOTS       (SLOTS),
      .ARROW_SIZE  (ARROW_SIZE),
      .ARROWY_BEGIN(ARROWY_BEGIN),
      .ARROW_SPEED (ARROW_SPEED),
      .TARGET_Y    (TARGET_Y),
      .HIT_WINDOW  (HIT_WINDOW),
      .X_ORIGIN    (lane_x_f(LANES, ARROW_SIZE, ARROW_GAP, SCREEN_W, l))
    ) u_lane (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .sx       (sx_i),
      .sy       (sy_i),
      .frame    (frame_i),
      .launch   (launch_i[l]),
      .press    (press[l]),
      .arrow    (arrow_o[l]),
      .hit      (hit_o[l]),
      .miss     (lane_miss[l]),
      .drop     (drop_o[l]),
      .hit_now  (hit_now[l]),
      .stray_now(stray_now[l])
    );
  end

  // Two guard bits let hits and penalties be summed signed before clamping.
  always_comb begin
    score_sum = $signed({2'b00, score_o}) + SW'($countones(hit_now));
`ifdef ARROW_LANE_PENALTY_EN
    score_sum = score_sum - SW'($countones(stray_now));
`endif
    if (score_sum[SW-1])
      score_d = '0;
    else if (score_sum > $signed({2'b00, {SCOREW{1'b1}}}))
      score_d = '1;
    else
      score_d = score_sum[SCOREW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) score_o <= '0;
    else         score_o <= score_d;
  end

`ifdef ARROW_LANE_PENALTY_EN
  logic [LANES-1:0] stray_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stray_q <= '0;
    else         stray_q <= stray_now;
  end

  assign miss_o = lane_miss | stray_q;
`else
  logic [LANES-1:0] unused_stray;

  assign unused_stray = stray_now;
  assign miss_o       = lane_miss;
`endif

endmodule

// File: tb/tb_arrow_lane_engine.sv
// Scoreboard bench for arrow_lane_engine: directed scenarios then random traffic,
// checked against a slot-list reference model.
module tb_arrow_lane_engine;

  localparam int CORDW    = 10;
  localparam int LANES    = 4;
  localparam int SLOTS    = 4;
  localparam int SIZE     = 50;
  localparam int GAP      = 10;
  localparam int SCREEN_W = 640;
  localparam int BEGIN_Y  = 450;
  localparam int SPEED    = 10;
  localparam int TARGET_Y = 40;
  localparam int WIN      = 20;
  localparam int SCOREW   = 16;
  localparam int SCORE_MAX = (1 << SCOREW) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [CORDW-1:0] sx_i = '0;
  logic [CORDW-1:0] sy_i = '0;
  logic             frame_i = 1'b0;
  logic [LANES-1:0] launch_i = '0;
  logic [LANES-1:0] btn_i = '0;
  logic [LANES-1:0] arrow_o, hit_o, miss_o, drop_o;
  logic [SCOREW-1:0] score_o;

  arrow_lane_engine #(
    .CORDW(CORDW), .LANES(LANES), .SLOTS(SLOTS), .ARROW_SIZE(SIZE), .ARROW_GAP(GAP),
    .SCREEN_W(SCREEN_W), .ARROWY_BEGIN(BEGIN_Y), .ARROW_SPEED(SPEED), .TARGET_Y(TARGET_Y),
    .HIT_WINDOW(WIN), .SCOREW(SCOREW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .sx_i(sx_i), .sy_i(sy_i), .frame_i(frame_i),
    .launch_i(launch_i), .btn_i(btn_i), .arrow_o(arrow_o), .hit_o(hit_o),
    .miss_o(miss_o), .drop_o(drop_o), .score_o(score_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] hit;
    logic [LANES-1:0] miss;
    logic [LANES-1:0] drop;
    int               score;
  } exp_t;

  exp_t             reg_q[$];
  logic [LANES-1:0] arrow_q[$];
  int               n_checks = 0;
  int               n_fails  = 0;

  bit               m_valid [LANES][SLOTS];
  int               m_y     [LANES][SLOTS];
  bit [LANES-1:0]   m_prev_btn;
  int               m_score;

  function automatic int lane_x(input int l);
    return (SCREEN_W - (LANES * SIZE + (LANES - 1) * GAP)) / 2 + l * (SIZE + GAP);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < SLOTS; s++) begin
        m_valid[l][s] = 1'b0;
        m_y[l][s]     = 0;
      end
    m_prev_btn = '1;
    m_score    = 0;
  endtask

  // Drive one cycle of inputs, queue the pixel answer for this cycle and the pulses for the next.
  task automatic apply_stimulus(input bit fr, input bit [LANES-1:0] la, input bit [LANES-1:0] bt,
                                input int sx, input int sy);
    exp_t           e;
    bit [LANES-1:0] ar;
    int             delta;
    frame_i  = fr;
    launch_i = la;
    btn_i    = bt;
    sx_i     = CORDW'(sx);
    sy_i     = CORDW'(sy);
    ar = '0;
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < SLOTS; s++)
        if (m_valid[l][s] && sx >= lane_x(l) && sx < lane_x(l) + SIZE &&
            sy >= m_y[l][s] && sy < m_y[l][s] + SIZE)
          ar[l] = 1'b1;
    arrow_q.push_back(ar);
    e.hit = '0; e.miss = '0; e.drop = '0;
    delta = 0;
    for (int l = 0; l < LANES; l++) begin
      bit press;
      int hs, free;
      press = bt[l] && !m_prev_btn[l];
      hs = -1;
      free = -1;
      for (int s = 0; s < SLOTS; s++) begin
        if (press && m_valid[l][s] && m_y[l][s] >= TARGET_Y - WIN && m_y[l][s] <= TARGET_Y + WIN &&
            (hs < 0 || m_y[l][s] < m_y[l][hs]))
          hs = s;
        if (!m_valid[l][s] && free < 0) free = s;
      end
      if (hs >= 0) begin
        m_valid[l][hs] = 1'b0;
        e.hit[l] = 1'b1;
        delta++;
      end else if (press) begin
`ifdef ARROW_LANE_PENALTY_EN
        e.miss[l] = 1'b1;
        delta--;
`endif
      end
      if (fr)
        for (int s = 0; s < SLOTS; s++)
          if (m_valid[l][s]) begin
            if (m_y[l][s] >= SPEED) m_y[l][s] -= SPEED;
            else begin
              m_valid[l][s] = 1'b0;
              e.miss[l] = 1'b1;
            end
          end
      if (la[l]) begin
        if (free >= 0) begin
          m_valid[l][free] = 1'b1;
          m_y[l][free]     = BEGIN_Y;
        end else e.drop[l] = 1'b1;
      end
    end
    m_prev_btn = bt;
    m_score += delta;
    if (m_score < 0) m_score = 0;
    if (m_score > SCORE_MAX) m_score = SCORE_MAX;
    e.score = m_score;
    reg_q.push_back(e);
  endtask

  task automatic cycle(input bit fr, input bit [LANES-1:0] la, input bit [LANES-1:0] bt,
                       input int sx, input int sy);
    @(posedge clk);
    #2;
    apply_stimulus(fr, la, bt, sx, sy);
  endtask

  task automatic check_output(input string tag);
    check({tag, " arrow_o"}, 32'(arrow_o), 32'd0);
    check({tag, " hit_o"},   32'(hit_o),   32'd0);
    check({tag, " miss_o"},  32'(miss_o),  32'd0);
    check({tag, " drop_o"},  32'(drop_o),  32'd0);
    check({tag, " score_o"}, 32'(score_o), 32'd0);
  endtask

  // Reset keeps the pixel probe where it was so arrow_o going low is meaningful.
  task automatic do_reset(input bit [LANES-1:0] hold_btn);
    rst_n    = 1'b0;
    frame_i  = 1'b0;
    launch_i = '0;
    btn_i    = hold_btn;
    reg_q.delete();
    arrow_q.delete();
    #1;
    check_output("reset");
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : arrow_monitor
    logic [LANES-1:0] a;
    forever begin
      @(negedge clk);
      if (rst_n && arrow_q.size() > 0) begin
        a = arrow_q.pop_front();
        check("arrow_o", 32'(arrow_o), 32'(a));
      end
    end
  end

  initial begin : pulse_monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && reg_q.size() > 0) begin
        e = reg_q.pop_front();
        check("hit_o",   32'(hit_o),   32'(e.hit));
        check("miss_o",  32'(miss_o),  32'(e.miss));
        check("drop_o",  32'(drop_o),  32'(e.drop));
        check("score_o", 32'(score_o), 32'(e.score));
      end
    end
  end

  initial begin : stimulus
    bit [LANES-1:0] lvl;
    #1;
    do_reset('0);

    // Lane 0 falls all the way and misses.
    cycle(1'b0, 4'b0001, '0, lane_x(0), 0);
    cycle(1'b0, '0, '0, lane_x(0) + 25, BEGIN_Y);
    for (int f = 0; f < 46; f++) cycle(1'b1, '0, '0, lane_x(0) + 25, m_y[0][0]);
    repeat (2) cycle(1'b0, '0, '0, 0, 0);
    do_reset('0);

    // Lane 1 pressed exactly on the target line.
    cycle(1'b0, 4'b0010, '0, 0, 0);
    for (int f = 0; f < 41; f++) cycle(1'b1, '0, '0, lane_x(1) + 10, m_y[1][0] + 49);
    cycle(1'b0, '0, 4'b0010, lane_x(1), TARGET_Y);
    repeat (2) cycle(1'b0, '0, '0, lane_x(1), TARGET_Y);
    do_reset('0);

    // Press while the arrow is still above the window.
    cycle(1'b0, 4'b0010, '0, 0, 0);
    for (int f = 0; f < 38; f++) cycle(1'b1, '0, '0, 0, 0);
    cycle(1'b0, '0, 4'b0010, lane_x(1), 70);
    repeat (2) cycle(1'b0, '0, '0, lane_x(1), 70);
    do_reset('0);

    // Lane 2 overflow.
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0100, '0, lane_x(2), BEGIN_Y);
    repeat (2) cycle(1'b0, '0, '0, lane_x(2) + 49, BEGIN_Y + 49);
    do_reset('0);

    // Lane 3: hit, move and launch in one cycle.
    cycle(1'b0, 4'b1000, '0, 0, 0);
    for (int f = 0; f < 42; f++) cycle(1'b1, '0, '0, 0, 0);
    cycle(1'b1, 4'b1000, 4'b1000, lane_x(3), 30);
    cycle(1'b0, '0, 4'b1000, lane_x(3), BEGIN_Y);
    cycle(1'b0, '0, '0, lane_x(3), 30);
    do_reset('0);

    // Pixel boundary, then reset with an arrow under the probe and a button held.
    cycle(1'b0, 4'b0001, '0, 0, 0);
    cycle(1'b0, '0, '0, lane_x(0) + 49, BEGIN_Y);
    cycle(1'b0, '0, '0, lane_x(0) + 50, BEGIN_Y);
    cycle(1'b0, '0, '0, lane_x(0) - 1, BEGIN_Y);
    cycle(1'b0, '0, '0, lane_x(0) + 49, BEGIN_Y);
    do_reset(4'b0001);
    cycle(1'b0, '0, 4'b0001, lane_x(0) + 49, BEGIN_Y);
    cycle(1'b0, '0, '0, 0, 0);

    // Random traffic.
    lvl = '0;
    for (int c = 0; c < 3000; c++) begin
      bit fr;
      bit [LANES-1:0] la;
      fr = ($urandom_range(0, 2) == 0);
      la = '0;
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(0, 9) == 0) la[l] = 1'b1;
        if ($urandom_range(0, 3) == 0) lvl[l] = ~lvl[l];
      end
      cycle(fr, la, lvl, 200 + $urandom_range(0, 260), $urandom_range(0, 510));
    end
    repeat (3) cycle(1'b0, '0, '0, 0, 0);
    @(posedge clk);
    #3;
    check("pulse queue drained", 32'(reg_q.size()), 32'd0);
    @(negedge clk);
    #1;
    check("arrow queue drained", 32'(arrow_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
